data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl_pkg.sv | 15 +
 rtl/dmem_byte_bank.sv | 31 +++
 rtl/data_memory_ctrl.sv | 165 ++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the byte-addressable data memory controller:
// access-size encoding and the controller FSM state type.
package data_memory_ctrl_pkg;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_byte_bank.sv
// Row-organised storage with per-byte write enables, synchronous write and
// combinational read. Lane k holds the byte at row offset k (lane 0 is the MSB).
module dmem_byte_bank
    import data_memory_ctrl_pkg::*;
#(
    parameter  int WORD_BYTES = 2,
    parameter  int DEPTH      = 128,
    localparam int ROWS       = DEPTH / WORD_BYTES,
    localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic [WORD_BYTES-1:0]   byte_we,
    input  logic [ROW_W-1:0]        row,
    input  logic [8*WORD_BYTES-1:0] wdata,
    output logic [8*WORD_BYTES-1:0] rdata
);

    logic [8*WORD_BYTES-1:0] mem [ROWS];

    // No reset: contents survive a controller reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (byte_we[k]) begin
                mem[row][8*(WORD_BYTES-1-k) +: 8] <= wdata[8*(WORD_BYTES-1-k) +: 8];
            end
        end
    end

    assign rdata = mem[row];

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-port data memory controller: byte/word loads and stores, big-endian,
// misaligned words split over two row accesses, out-of-range requests flagged.
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int WORD_BYTES = 2,
    parameter int DEPTH      = 128,
    parameter int ADDR_W     = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic                    ReqWrite,
    input  logic                    ReqSize,
    input  logic                    ReqSigned,
    input  logic [ADDR_W-1:0]       Adresa,
    input  logic [8*WORD_BYTES-1:0] WriteData,
    output logic                    RespValid,
    output logic [8*WORD_BYTES-1:0] ReadData,
    output logic                    RespErr
);

    localparam int DW    = 8 * WORD_BYTES;
    localparam int ROWS  = DEPTH / WORD_BYTES;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    // Wide enough that address + access size never wraps.
    localparam int EXT_W = (ADDR_W > 30) ? ADDR_W + 2 : 32;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              size_q, size_d;
    logic              signed_q, signed_d;
    logic [DW-1:0]     asm_q, asm_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DW-1:0]     read_data_q, read_data_d;

    logic [EXT_W-1:0]      addr_ext, nbytes, acc_row;
    logic [EXT_W-1:0]      boff [WORD_BYTES];
    logic                  out_of_range, misaligned, in_access;
    logic [WORD_BYTES-1:0] bank_we;
    logic [DW-1:0]         bank_wdata, bank_rdata;

    function automatic logic [DW-1:0] load_result(input logic [DW-1:0] word,
                                                  input logic sz, input logic sg);
        logic [7:0] b;
        b = word[DW-1 -: 8];
        if (sz == SIZE_WORD) return word;
        return sg ? {{(DW-8){b[7]}}, b} : {{(DW-8){1'b0}}, b};
    endfunction

    assign addr_ext     = EXT_W'(addr_q);
    assign nbytes       = (size_q == SIZE_BYTE) ? EXT_W'(1) : EXT_W'(WORD_BYTES);
    assign out_of_range = (addr_ext + nbytes) > EXT_W'(DEPTH);
    assign misaligned   = (size_q == SIZE_WORD) && ((addr_ext % EXT_W'(WORD_BYTES)) != '0);
    assign in_access    = ((state_q == ACC0) || (state_q == ACC1)) && !out_of_range;
    assign acc_row      = addr_ext / EXT_W'(WORD_BYTES)
                        + ((state_q == ACC1) ? EXT_W'(1) : EXT_W'(0));

    // Offset of each lane of the current row relative to the request address;
    // lanes before the address wrap to huge values and fall outside the access.
    always_comb begin
        for (int k = 0; k < WORD_BYTES; k++) begin
            boff[k] = acc_row * EXT_W'(WORD_BYTES) + EXT_W'(k) - addr_ext;
        end
    end

    dmem_byte_bank #(
        .WORD_BYTES (WORD_BYTES),
        .DEPTH      (DEPTH)
    ) u_bank (
        .clk     (Clock),
        .byte_we (bank_we),
        .row     (ROW_W'(acc_row)),
        .wdata   (bank_wdata),
        .rdata   (bank_rdata)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        asm_d        = asm_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        read_data_d  = read_data_q;
        bank_we      = '0;
        bank_wdata   = '0;

        for (int k = 0; k < WORD_BYTES; k++) begin
            if (in_access && (boff[k] < nbytes)) begin
                bank_we[k] = write_q;
                bank_wdata[8*(WORD_BYTES-1-k) +: 8] = (size_q == SIZE_WORD)
                    ? 8'(wdata_q >> (8*(WORD_BYTES-1-int'(boff[k]))))
                    : wdata_q[7:0];
                asm_d[8*(WORD_BYTES-1-int'(boff[k])) +: 8] = bank_rdata[8*(WORD_BYTES-1-k) +: 8];
            end
        end

        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    addr_d   = Adresa;
                    wdata_d  = WriteData;
                    write_d  = ReqWrite;
                    size_d   = ReqSize;
                    signed_d = ReqSigned;
                    asm_d    = '0;
                    state_d  = ACC0;
                end
            end
            ACC0:    state_d = (misaligned && !out_of_range) ? ACC1 : RESP;
            ACC1:    state_d = RESP;
            RESP: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = out_of_range;
                if (out_of_range) begin
                    read_data_d = '0;
                end else if (!write_q) begin
                    read_data_d = load_result(asm_q, size_q, signed_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            size_q       <= 1'b0;
            signed_q     <= 1'b0;
            asm_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            read_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            asm_q        <= asm_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            read_data_q  <= read_data_d;
        end
    end

    assign ReqReady  = (state_q == IDLE);
    assign RespValid = resp_valid_q;
    assign RespErr   = resp_err_q;
    assign ReadData  = read_data_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed scenarios plus randomized traffic checked
// against a byte-array reference model of the memory.
module tb_data_memory_ctrl;

    localparam int WB    = 2;
    localparam int DEPTH = 128;
    localparam int AW    = 16;
    localparam int DW    = 8 * WB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0, req_write = 1'b0, req_size = 1'b0, req_signed = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          req_ready, resp_valid, resp_err;
    logic [DW-1:0] read_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    mem_m [DEPTH];
    logic [DW-1:0] last_rd = '0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.WORD_BYTES(WB), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .Clock     (clk),
        .Reset     (rst),
        .ReqValid  (req_valid),
        .ReqReady  (req_ready),
        .ReqWrite  (req_write),
        .ReqSize   (req_size),
        .ReqSigned (req_signed),
        .Adresa    (addr),
        .WriteData (wdata),
        .RespValid (resp_valid),
        .ReadData  (read_data),
        .RespErr   (resp_err)
    );

    // Reference: flat byte array, big-endian words, range check on unwrapped ints.
    task automatic model(input logic w, input logic sz, input logic sg, input int a,
                         input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd,
                         output logic err);
        int n;
        n   = sz ? WB : 1;
        err = (a + n > DEPTH);
        lat = (!err && sz && (a % WB != 0)) ? 3 : 2;
        if (err) rd = '0;
        else if (w) begin
            for (int i = 0; i < n; i++) mem_m[a+i] = sz ? 8'(d >> (8*(WB-1-i))) : d[7:0];
            rd = last_rd;
        end else if (sz) begin
            rd = '0;
            for (int i = 0; i < n; i++) rd = (rd << 8) | DW'(mem_m[a+i]);
        end else begin
            rd = sg ? DW'($signed(mem_m[a])) : DW'(mem_m[a]);
        end
        last_rd = rd;
    endtask

    // Issues one request and observes the response: latency (edges after acceptance),
    // data, error, whether ReqReady behaved, and whether the response was a 1-cycle pulse.
    task automatic run_req(input logic w, input logic sz, input logic sg, input int a,
                           input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd,
                           output logic err, output logic hs_ok, output logic pulse_ok);
        @(negedge clk);
        hs_ok = (req_ready === 1'b1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        addr = AW'(a); wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0; addr = AW'($urandom); wdata = DW'($urandom);
        if (req_ready !== 1'b0) hs_ok = 1'b0;
        lat = -1; rd = '0; err = 1'b0; pulse_ok = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (resp_valid === 1'b1) begin
                lat = c; rd = read_data; err = resp_err;
                if (req_ready !== 1'b1) hs_ok = 1'b0;
                break;
            end
            if (req_ready !== 1'b0) hs_ok = 1'b0;
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            pulse_ok = (resp_valid === 1'b0) && (resp_err === 1'b0) && (read_data === rd);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b, required 1 0 0", req_ready, resp_valid, resp_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (read_data !== '0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: rdata=%h ready=%b, required 0000 1", read_data, req_ready);
        end
        last_rd = '0;
    endtask

    task automatic init_mem();
        int lat; logic [DW-1:0] rd; logic err, hs, pl;
        int el; logic [DW-1:0] er; logic ee;
        for (int a = 0; a < DEPTH; a += WB) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            model(1'b1, 1'b1, 1'b0, a, d, el, er, ee);
            run_req(1'b1, 1'b1, 1'b0, a, d, lat, rd, err, hs, pl);
        end
    endtask

    task automatic test_aligned_word();
        int lat, el; logic [DW-1:0] rd, er; logic err, ee, hs, pl;
        model(1'b1, 1'b1, 1'b0, 'h10, 16'hA1B2, el, er, ee);
        run_req(1'b1, 1'b1, 1'b0, 'h10, 16'hA1B2, lat, rd, err, hs, pl);
        n_checks++;
        if (lat !== 2 || err !== 1'b0) begin
            n_fail++; $display("FAIL aligned_store: lat=%0d err=%b, required 2 0", lat, err);
        end
        model(1'b0, 1'b1, 1'b0, 'h10, '0, el, er, ee);
        run_req(1'b0, 1'b1, 1'b0, 'h10, '0, lat, rd, err, hs, pl);
        n_checks++;
        if (lat !== 2 || rd !== 16'hA1B2 || err !== 1'b0) begin
            n_fail++; $display("FAIL aligned_load: lat=%0d rd=%h err=%b, required 2 a1b2 0", lat, rd, err);
        end
        n_checks++;
        if (hs !== 1'b1 || pl !== 1'b1) begin
            n_fail++; $display("FAIL aligned_handshake: ready_ok=%b pulse_ok=%b, required 1 1", hs, pl);
        end
        model(1'b0, 1'b0, 1'b0, 'h11, '0, el, er, ee);
        run_req(1'b0, 1'b0, 1'b0, 'h11, '0, lat, rd, err, hs, pl);
        n_checks++;
        if (lat !== 2 || rd !== 16'h00B2) begin
            n_fail++; $display("FAIL byte_load_lsb: lat=%0d rd=%h, required 2 00b2", lat, rd);
        end
    endtask

    task automatic test_misaligned();
        int lat, el; logic [DW-1:0] rd, er; logic err, ee, hs, pl;
        model(1'b1, 1'b1, 1'b0, 'h21, 16'h1234, el, er, ee);
        run_req(1'b1, 1'b1, 1'b0, 'h21, 16'h1234, lat, rd, err, hs, pl);
        n_checks++;
        if (lat !== 3 || err !== 1'b0) begin
            n_fail++; $display("FAIL misaligned_store: lat=%0d err=%b, required 3 0", lat, err);
        end
        model(1'b0, 1'b1, 1'b0, 'h21, '0, el, er, ee);
        run_req(1'b0, 1'b1, 1'b0, 'h21, '0, lat, rd, err, hs, pl);
        n_checks++;
        if (lat !== 3 || rd !== 16'h1234 || hs !== 1'b1 || pl !== 1'b1) begin
            n_fail++; $display("FAIL misaligned_load: lat=%0d rd=%h ready_ok=%b pulse_ok=%b, required 3 1234 1 1", lat, rd, hs, pl);
        end
        for (int a = 'h20; a <= 'h22; a += 2) begin
            model(1'b0, 1'b0, 1'b0, a, '0, el, er, ee);
            run_req(1'b0, 1'b0, 1'b0, a, '0, lat, rd, err, hs, pl);
            n_checks++;
            if (rd !== er || lat !== 2) begin
                n_fail++; $display("FAIL misaligned_neighbour @%h: rd=%h lat=%0d, required %h 2", a, rd, lat, er);
            end
        end
    endtask

    task automatic test_byte_store();
        int lat, el; logic [DW-1:0] rd, er; logic err, ee, hs, pl;
        model(1'b1, 1'b0, 1'b0, 'h05, 16'hAA80, el, er, ee);
        run_req(1'b1, 1'b0, 1'b0, 'h05, 16'hAA80, lat, rd, err, hs, pl);
        model(1'b0, 1'b0, 1'b1, 'h05, '0, el, er, ee);
        run_req(1'b0, 1'b0, 1'b1, 'h05, '0, lat, rd, err, hs, pl);
        n_checks++;
        if (rd !== 16'hFF80 || lat !== 2) begin
            n_fail++; $display("FAIL byte_signed: rd=%h lat=%0d, required ff80 2", rd, lat);
        end
        model(1'b0, 1'b0, 1'b0, 'h05, '0, el, er, ee);
        run_req(1'b0, 1'b0, 1'b0, 'h05, '0, lat, rd, err, hs, pl);
        n_checks++;
        if (rd !== 16'h0080) begin
            n_fail++; $display("FAIL byte_unsigned: rd=%h, required 0080", rd);
        end
        model(1'b0, 1'b0, 1'b0, 'h04, '0, el, er, ee);
        run_req(1'b0, 1'b0, 1'b0, 'h04, '0, lat, rd, err, hs, pl);
        n_checks++;
        if (rd !== er) begin
            n_fail++; $display("FAIL byte_neighbour: rd=%h, required %h", rd, er);
        end
    endtask

    task automatic test_range();
        int lat, el; logic [DW-1:0] rd, er; logic err, ee, hs, pl;
        model(1'b0, 1'b1, 1'b0, 'h7F, '0, el, er, ee);
        run_req(1'b0, 1'b1, 1'b0, 'h7F, '0, lat, rd, err, hs, pl);
        n_checks++;
        if (err !== 1'b1 || rd !== '0 || lat !== 2) begin
            n_fail++; $display("FAIL range_load: err=%b rd=%h lat=%0d, required 1 0000 2", err, rd, lat);
        end
        model(1'b1, 1'b1, 1'b0, 'h7F, 16'h5A5A, el, er, ee);
        run_req(1'b1, 1'b1, 1'b0, 'h7F, 16'h5A5A, lat, rd, err, hs, pl);
        n_checks++;
        if (err !== 1'b1 || lat !== 2 || pl !== 1'b1) begin
            n_fail++; $display("FAIL range_store: err=%b lat=%0d pulse_ok=%b, required 1 2 1", err, lat, pl);
        end
        model(1'b0, 1'b0, 1'b0, 'h7F, '0, el, er, ee);
        run_req(1'b0, 1'b0, 1'b0, 'h7F, '0, lat, rd, err, hs, pl);
        n_checks++;
        if (err !== 1'b0 || rd !== er) begin
            n_fail++; $display("FAIL range_last_byte: err=%b rd=%h, required 0 %h", err, rd, er);
        end
        model(1'b0, 1'b1, 1'b0, 'hFFFF, '0, el, er, ee);
        run_req(1'b0, 1'b1, 1'b0, 'hFFFF, '0, lat, rd, err, hs, pl);
        n_checks++;
        if (err !== 1'b1 || rd !== '0) begin
            n_fail++; $display("FAIL range_wrap: err=%b rd=%h, required 1 0000", err, rd);
        end
        model(1'b0, 1'b1, 1'b0, 'h7E, '0, el, er, ee);
        run_req(1'b0, 1'b1, 1'b0, 'h7E, '0, lat, rd, err, hs, pl);
        n_checks++;
        if (err !== 1'b0 || rd !== er) begin
            n_fail++; $display("FAIL range_last_word: err=%b rd=%h, required 0 %h", err, rd, er);
        end
    endtask

    task automatic test_back_to_back();
        int el; logic [DW-1:0] exp_a, exp_b; logic ee;
        logic exp_rv [6];
        logic exp_rdy [6];
        exp_rv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        model(1'b0, 1'b1, 1'b0, 'h10, '0, el, exp_a, ee);
        model(1'b0, 1'b1, 1'b0, 'h20, '0, el, exp_b, ee);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 1'b1; req_signed = 1'b0; addr = 'h10;
        @(posedge clk);
        #1 addr = 'h20;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c == 3) req_valid = 1'b0;
            n_checks++;
            if (resp_valid !== exp_rv[c] || req_ready !== exp_rdy[c]) begin
                n_fail++; $display("FAIL b2b_cycle%0d: valid=%b ready=%b, required %b %b", c, resp_valid, req_ready, exp_rv[c], exp_rdy[c]);
            end
            if (c == 2 || c == 5) begin
                n_checks++;
                if (read_data !== ((c == 2) ? exp_a : exp_b)) begin
                    n_fail++; $display("FAIL b2b_data%0d: rd=%h, required %h", c, read_data, (c == 2) ? exp_a : exp_b);
                end
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_no_third: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_random();
        int lat, el, a; logic [DW-1:0] rd, er, d; logic err, ee, hs, pl, w, sz, sg;
        for (int i = 0; i < 60; i++) begin
            w  = 1'($urandom); sz = 1'($urandom); sg = 1'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, DEPTH + 1));
            d  = DW'($urandom);
            model(w, sz, sg, a, d, el, er, ee);
            run_req(w, sz, sg, a, d, lat, rd, err, hs, pl);
            n_checks++;
            if (lat !== el || rd !== er || err !== ee || hs !== 1'b1 || pl !== 1'b1) begin
                n_fail++;
                $display("FAIL random%0d w=%b sz=%b sg=%b a=%h: lat=%0d rd=%h err=%b ready_ok=%b pulse_ok=%b, required %0d %h %b 1 1",
                         i, w, sz, sg, a, lat, rd, err, hs, pl, el, er, ee);
            end
        end
    endtask

    task automatic test_reset_acc1();
        int lat, el; logic [DW-1:0] rd, er; logic err, ee, hs, pl, seen;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_signed = 1'b0;
        addr = 'h31; wdata = 16'hBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_m['h31] = 8'hBE;
        last_rd = '0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1 if (resp_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0 || req_ready !== 1'b1 || read_data !== '0) begin
            n_fail++; $display("FAIL reset_acc1_idle: resp_seen=%b ready=%b rd=%h, required 0 1 0000", seen, req_ready, read_data);
        end
        model(1'b0, 1'b0, 1'b0, 'h31, '0, el, er, ee);
        run_req(1'b0, 1'b0, 1'b0, 'h31, '0, lat, rd, err, hs, pl);
        n_checks++;
        if (rd !== 16'h00BE) begin
            n_fail++; $display("FAIL reset_acc1_first: rd=%h, required 00be", rd);
        end
        model(1'b0, 1'b0, 1'b0, 'h32, '0, el, er, ee);
        run_req(1'b0, 1'b0, 1'b0, 'h32, '0, lat, rd, err, hs, pl);
        n_checks++;
        if (rd !== er) begin
            n_fail++; $display("FAIL reset_acc1_second: rd=%h, required %h", rd, er);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        init_mem();
        test_aligned_word();
        test_misaligned();
        test_byte_store();
        test_range();
        test_back_to_back();
        test_random();
        test_reset_acc1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
